// File: rtl/sync_fifo_pkg.sv
// Shared width helpers and parameter legality checks for the interleaved FIFO,
// its bank RAMs and its prefetch buffer.
package sync_fifo_pkg;

  function automatic bit is_pow2(input int unsigned n);
    return (n != 0) && ((n & (n - 1)) == 0);
  endfunction

  // Index width for a pointer that wraps modulo depth.
  function automatic int unsigned ptr_width(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  // Width able to hold an occupancy from 0 up to and including depth.
  function automatic int unsigned occ_width(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

  function automatic int unsigned bank_sel_width(input int unsigned banks);
    return (banks > 1) ? $clog2(banks) : 1;
  endfunction

  function automatic bit params_ok(input int unsigned depth, input int unsigned banks,
                                   input int unsigned pf, input int unsigned afull,
                                   input int unsigned aempty);
    return is_pow2(depth) && is_pow2(banks) && (banks >= 2) && (depth >= 2 * banks) &&
           (pf >= 3) && (afull <= depth) && (aempty <= depth);
  endfunction

endpackage

// File: rtl/reg_fifo.sv
// Small register-based FIFO; head entry is presented combinationally on o_data.
module reg_fifo
  import sync_fifo_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned DEPTH      = 4
) (
  input  logic                        clk,
  input  logic                        rstn,
  input  logic                        i_clear,
  input  logic                        i_push,
  input  logic [DATA_WIDTH-1:0]       i_data,
  input  logic                        i_pop,
  output logic [DATA_WIDTH-1:0]       o_data,
  output logic                        o_valid,
  output logic [occ_width(DEPTH)-1:0] o_count
);

  localparam int unsigned IdxW = ptr_width(DEPTH);
  localparam int unsigned CntW = occ_width(DEPTH);

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [IdxW-1:0]       r_head, r_tail;
  logic [CntW-1:0]       r_count;
  logic                  w_push, w_pop;

  // DEPTH need not be a power of two, so wrap explicitly.
  function automatic logic [IdxW-1:0] next_idx(input logic [IdxW-1:0] idx);
    return (idx == IdxW'(DEPTH - 1)) ? '0 : idx + IdxW'(1);
  endfunction

  assign w_push = i_push && (r_count != CntW'(DEPTH));
  assign w_pop  = i_pop && (r_count != '0);

  always_ff @(posedge clk) begin
    if (!rstn || i_clear) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_tail <= next_idx(r_tail);
      if (w_pop)  r_head <= next_idx(r_head);
      r_count <= r_count + CntW'(w_push) - CntW'(w_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_tail] <= i_data;
  end

  assign o_data  = r_mem[r_head];
  assign o_valid = (r_count != '0);
  assign o_count = r_count;

endmodule

// File: rtl/single_port_RAM.sv
// Single-port RAM, one access per cycle, registered read data, no reset on contents.
module single_port_RAM
  import sync_fifo_pkg::*;
#(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned WIDTH = 8
) (
  input  logic                        clk,
  input  logic                        i_en,
  input  logic                        i_we,
  input  logic [ptr_width(DEPTH)-1:0] i_addr,
  input  logic [WIDTH-1:0]            i_wdata,
  output logic [WIDTH-1:0]            o_rdata
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [WIDTH-1:0] r_rdata;

  always_ff @(posedge clk) begin
    if (i_en) begin
      if (i_we) begin
        r_mem[i_addr] <= i_wdata;
      end else begin
        r_rdata <= r_mem[i_addr];
      end
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/sync_interleaved_fifo.sv
// FIFO striped across NUM_BANKS single-port RAMs with a prefetch buffer on the read side.
// Define SYNC_INTERLEAVED_FIFO_STATUS_EN to enable the registered almost_full/almost_empty flags.
module sync_interleaved_fifo
  import sync_fifo_pkg::*;
#(
  parameter int unsigned DATA_WIDTH     = 8,
  parameter int unsigned FIFO_DEPTH     = 256,
  parameter int unsigned NUM_BANKS      = 2,
  parameter int unsigned PREFETCH_DEPTH = 4,
  parameter int unsigned AFULL_LEVEL    = FIFO_DEPTH - 4,
  parameter int unsigned AEMPTY_LEVEL   = 4
) (
  input  logic                        clk,
  input  logic                        rstn,
  input  logic [DATA_WIDTH-1:0]       in_data,
  input  logic                        in_valid,
  output logic                        in_ready,
  output logic [DATA_WIDTH-1:0]       out_data,
  output logic                        out_valid,
  input  logic                        out_ready,
  input  logic                        clear,
  output logic [$clog2(FIFO_DEPTH):0] count,
  output logic                        almost_full,
  output logic                        almost_empty
);

  localparam int unsigned PtrW      = ptr_width(FIFO_DEPTH);
  localparam int unsigned CntW      = occ_width(FIFO_DEPTH);
  localparam int unsigned BankW     = bank_sel_width(NUM_BANKS);
  localparam int unsigned AddrW     = PtrW - BankW;
  localparam int unsigned BankDepth = FIFO_DEPTH / NUM_BANKS;
  localparam int unsigned PfCntW    = occ_width(PREFETCH_DEPTH);
  localparam int unsigned PfSumW    = PfCntW + 1;

  if (!params_ok(FIFO_DEPTH, NUM_BANKS, PREFETCH_DEPTH, AFULL_LEVEL, AEMPTY_LEVEL))
  begin : g_bad_params
    $error("sync_interleaved_fifo: illegal parameter combination");
  end

  logic                  w_flush, w_wr, w_rd, w_rd_issue;
  logic [PtrW-1:0]       r_wptr, r_rptr;
  logic [CntW-1:0]       r_ram_occ, r_count, w_count_d;
  logic [BankW-1:0]      w_wbank, w_rbank, r_s1_bank;
  logic [AddrW-1:0]      w_waddr, w_raddr;
  logic                  r_s1_valid, r_s2_valid;
  logic [DATA_WIDTH-1:0] r_s2_data;
  logic [DATA_WIDTH-1:0] w_bank_rdata [NUM_BANKS];
  logic [PfCntW-1:0]     w_pf_count;
  logic [PfSumW-1:0]     w_pf_used;

  assign w_flush   = !rstn || clear;
  assign in_ready  = (r_count < CntW'(FIFO_DEPTH));
  assign w_wr      = in_valid && in_ready;
  assign w_rd      = out_valid && out_ready;
  assign w_count_d = r_count + CntW'(w_wr) - CntW'(w_rd);
  assign count     = r_count;

  // Low pointer bits pick the bank, the rest address within it.
  assign w_wbank = r_wptr[BankW-1:0];
  assign w_waddr = r_wptr[PtrW-1:BankW];
  assign w_rbank = r_rptr[BankW-1:0];
  assign w_raddr = r_rptr[PtrW-1:BankW];

  // Buffer slots already spoken for; a pop this cycle frees one in time for a new read.
  assign w_pf_used = PfSumW'(w_pf_count) + PfSumW'(r_s1_valid) + PfSumW'(r_s2_valid) -
                     PfSumW'(w_rd);
  assign w_rd_issue = (r_ram_occ != '0) && !(w_wr && (w_wbank == w_rbank)) &&
                      (w_pf_used < PfSumW'(PREFETCH_DEPTH));

  for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
    logic w_bwr, w_brd;
    assign w_bwr = w_wr && (w_wbank == BankW'(b));
    assign w_brd = w_rd_issue && (w_rbank == BankW'(b));

    single_port_RAM #(
      .DEPTH(BankDepth),
      .WIDTH(DATA_WIDTH)
    ) u_ram (
      .clk    (clk),
      .i_en   (w_bwr || w_brd),
      .i_we   (w_bwr),
      .i_addr (w_bwr ? w_waddr : w_raddr),
      .i_wdata(in_data),
      .o_rdata(w_bank_rdata[b])
    );
  end

  always_ff @(posedge clk) begin
    if (w_flush) begin
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_ram_occ  <= '0;
      r_count    <= '0;
      r_s1_valid <= 1'b0;
      r_s2_valid <= 1'b0;
    end else begin
      if (w_wr)       r_wptr <= r_wptr + PtrW'(1);
      if (w_rd_issue) r_rptr <= r_rptr + PtrW'(1);
      r_ram_occ  <= r_ram_occ + CntW'(w_wr) - CntW'(w_rd_issue);
      r_count    <= w_count_d;
      r_s1_valid <= w_rd_issue;
      r_s2_valid <= r_s1_valid;
    end
  end

  always_ff @(posedge clk) begin
    r_s1_bank <= w_rbank;
    r_s2_data <= w_bank_rdata[r_s1_bank];
  end

  reg_fifo #(
    .DATA_WIDTH(DATA_WIDTH),
    .DEPTH     (PREFETCH_DEPTH)
  ) u_prefetch (
    .clk    (clk),
    .rstn   (rstn),
    .i_clear(clear),
    .i_push (r_s2_valid),
    .i_data (r_s2_data),
    .i_pop  (w_rd),
    .o_data (out_data),
    .o_valid(out_valid),
    .o_count(w_pf_count)
  );

`ifdef SYNC_INTERLEAVED_FIFO_STATUS_EN
  logic r_afull, r_aempty;

  always_ff @(posedge clk) begin
    if (w_flush) begin
      r_afull  <= 1'b0;
      r_aempty <= 1'b1;
    end else begin
      r_afull  <= (w_count_d >= CntW'(AFULL_LEVEL));
      r_aempty <= (w_count_d <= CntW'(AEMPTY_LEVEL));
    end
  end

  assign almost_full  = r_afull;
  assign almost_empty = r_aempty;
`else
  assign almost_full  = 1'b0;
  assign almost_empty = 1'b0;
`endif

endmodule

// File: tb/tb_sync_interleaved_fifo.sv
// Directed bench for sync_interleaved_fifo (16 deep, 2 banks, 4-entry prefetch).
module tb_sync_interleaved_fifo;

  localparam int Depth = 16;
`ifdef SYNC_INTERLEAVED_FIFO_STATUS_EN
  localparam bit StatusEn = 1'b1;
`else
  localparam bit StatusEn = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rstn, in_valid, in_ready, out_valid, out_ready, clear;
  logic       almost_full, almost_empty;
  logic [7:0] in_data, out_data;
  logic [4:0] count;

  int         n_checks = 0;
  int         n_errors = 0;
  int         m_count  = 0;
  int         n_rcvd   = 0;
  logic [7:0] q[$];

  sync_interleaved_fifo #(
    .DATA_WIDTH    (8),
    .FIFO_DEPTH    (Depth),
    .NUM_BANKS     (2),
    .PREFETCH_DEPTH(4),
    .AFULL_LEVEL   (12),
    .AEMPTY_LEVEL  (4)
  ) dut (
    .clk         (clk),
    .rstn        (rstn),
    .in_data     (in_data),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .out_data    (out_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .clear       (clear),
    .count       (count),
    .almost_full (almost_full),
    .almost_empty(almost_empty)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    rstn = 1'b0; in_valid = 1'b0; in_data = 8'h00; out_ready = 1'b0; clear = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rstn = 1'b1;
    q.delete();
    m_count = 0;
  endtask

  // One clock: drive, predict the handshakes, advance, then score against the model.
  task automatic step(input logic iv, input logic [7:0] id, input logic ordy, input logic clr,
                      output logic acc_w);
    logic       popped;
    logic [7:0] exp_d;
    in_valid = iv; in_data = id; out_ready = ordy; clear = clr;
    acc_w  = iv && !clr && (m_count < Depth);
    popped = 1'b0;
    if (out_valid && ordy && !clr) begin
      if (q.size() == 0) begin
        check_eq("rd_unexpected", 32'(out_valid), 32'(0));
      end else begin
        exp_d = q.pop_front();
        check_eq("rd_data", 32'(out_data), 32'(exp_d));
        popped = 1'b1;
        n_rcvd++;
      end
    end
    @(posedge clk);
    #1;
    if (clr) begin
      q.delete();
      m_count = 0;
    end else begin
      if (acc_w) q.push_back(id);
      m_count = m_count + (acc_w ? 1 : 0) - (popped ? 1 : 0);
    end
    check_eq("count", 32'(count), 32'(m_count));
    check_eq("in_ready", 32'(in_ready), 32'(m_count < Depth));
    check_eq("almost_full", 32'(almost_full), 32'(StatusEn && (m_count >= 12)));
    check_eq("almost_empty", 32'(almost_empty), 32'(StatusEn && (m_count <= 4)));
  endtask

  initial begin
    #500000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    logic acc;
    int   wi;
    int   rcvd0;

    // Reset values
    do_reset();
    check_eq("rst_out_valid", 32'(out_valid), 32'(0));
    check_eq("rst_in_ready", 32'(in_ready), 32'(1));
    check_eq("rst_count", 32'(count), 32'(0));
    check_eq("rst_afull", 32'(almost_full), 32'(0));
    check_eq("rst_aempty", 32'(almost_empty), 32'(StatusEn));

    // Single word: accepted at edge 0, visible after edge 3
    step(1'b1, 8'hA5, 1'b0, 1'b0, acc);
    check_eq("sw_count", 32'(count), 32'(1));
    step(1'b0, 8'h00, 1'b0, 1'b0, acc);
    check_eq("sw_valid_e1", 32'(out_valid), 32'(0));
    step(1'b0, 8'h00, 1'b0, 1'b0, acc);
    check_eq("sw_valid_e2", 32'(out_valid), 32'(0));
    step(1'b0, 8'h00, 1'b0, 1'b0, acc);
    check_eq("sw_valid_e3", 32'(out_valid), 32'(1));
    check_eq("sw_data", 32'(out_data), 32'(8'hA5));
    step(1'b0, 8'h00, 1'b1, 1'b0, acc);
    check_eq("sw_count_after", 32'(count), 32'(0));
    check_eq("sw_valid_after", 32'(out_valid), 32'(0));

    // Streaming: writes at edges 0..999, reads must land on edges 4..1003 with no gaps
    do_reset();
    n_rcvd = 0;
    for (int i = 0; i < 1004; i++) step(i < 1000, 8'(i), 1'b1, 1'b0, acc);
    check_eq("stream_rcvd", 32'(n_rcvd), 32'(1000));
    check_eq("stream_left", 32'(q.size()), 32'(0));

    // Fill to full: 20 offered, 16 kept, drain yields 0..15
    do_reset();
    for (int i = 0; i < 20; i++) step(1'b1, 8'(i), 1'b0, 1'b0, acc);
    check_eq("full_in_ready", 32'(in_ready), 32'(0));
    check_eq("full_count", 32'(count), 32'(16));
    n_rcvd = 0;
    for (int i = 0; i < 40 && q.size() > 0; i++) step(1'b0, 8'h00, 1'b1, 1'b0, acc);
    check_eq("full_drained", 32'(n_rcvd), 32'(16));
    check_eq("full_count_end", 32'(count), 32'(0));

    // Wrap-around with random read backpressure
    do_reset();
    n_rcvd = 0;
    wi = 0;
    for (int c = 0; c < 3000 && n_rcvd < 48; c++) begin
      step(wi < 48, 8'(wi + 100), 1'($urandom_range(0, 1)), 1'b0, acc);
      if (acc) wi++;
    end
    check_eq("wrap_rcvd", 32'(n_rcvd), 32'(48));

    // Clear with count=7 and a prefetch read in flight
    do_reset();
    for (int i = 0; i < 7; i++) step(1'b1, 8'(8'h10 + i), 1'b0, 1'b0, acc);
    step(1'b1, 8'h17, 1'b1, 1'b0, acc);
    check_eq("clr_count_pre", 32'(count), 32'(7));
    step(1'b0, 8'h00, 1'b0, 1'b1, acc);
    check_eq("clr_count", 32'(count), 32'(0));
    check_eq("clr_valid", 32'(out_valid), 32'(0));
    check_eq("clr_in_ready", 32'(in_ready), 32'(1));
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 8'h00, 1'b1, 1'b0, acc);
      check_eq("clr_stale", 32'(out_valid), 32'(0));
    end
    rcvd0 = n_rcvd;
    step(1'b1, 8'h3C, 1'b0, 1'b0, acc);
    for (int i = 0; i < 10 && q.size() > 0; i++) step(1'b0, 8'h00, 1'b1, 1'b0, acc);
    check_eq("clr_first_rcvd", 32'(n_rcvd - rcvd0), 32'(1));

    // Status thresholds while filling
    do_reset();
    for (int i = 1; i <= 12; i++) begin
      step(1'b1, 8'(i), 1'b0, 1'b0, acc);
      if (i == 4)  check_eq("ae_at4", 32'(almost_empty), 32'(StatusEn));
      if (i == 5)  check_eq("ae_at5", 32'(almost_empty), 32'(0));
      if (i == 11) check_eq("af_at11", 32'(almost_full), 32'(0));
      if (i == 12) check_eq("af_at12", 32'(almost_full), 32'(StatusEn));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
